// File: rtl/rotor_pkg.sv
// Shared types and constants for the rotary encoder front end.
//   rot_state_e   : quadrature decoder states (rest plus three steps per direction)
//   ROT_DIR_CW    : rot_dir value for a clockwise step
//   ROT_DIR_CCW   : rot_dir value for a counter-clockwise step
//   ROT_REST_CODE : filtered {A,B} code at a detent
package rotor_pkg;

  typedef enum logic [2:0] {
    StRest,
    StCw1,
    StCw2,
    StCw3,
    StCcw1,
    StCcw2,
    StCcw3
  } rot_state_e;

  localparam logic       ROT_DIR_CW    = 1'b1;
  localparam logic       ROT_DIR_CCW   = 1'b0;
  localparam logic [1:0] ROT_REST_CODE = 2'b00;

endpackage

// File: rtl/rotor_debounce.sv
// Two-flop synchroniser followed by a stability filter for one raw input line.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   raw_i  : asynchronous raw line
//   filt_o : filtered level; follows raw_i after DEBOUNCE_CYCLES stable cycles
module rotor_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 5000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic filt_o
);

  localparam logic [15:0] Limit = 16'(DEBOUNCE_CYCLES);

  logic        sync1_q, sync2_q;
  logic        filt_d, filt_q;
  logic [15:0] cnt_d, cnt_q;
  logic [15:0] cnt_inc;

  // Counter never exceeds Limit-1 (<= 65534), so the increment cannot wrap.
  assign cnt_inc = cnt_q + 16'd1;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_inc == Limit) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/rotor_decoder.sv
// Rotary encoder front end: debounces A, B and CENTER, decodes full quadrature
// detent cycles into one-cycle step pulses with direction, and emits a press pulse.
// Optional macro ROTOR_POSITION_EN builds an 8-bit detent position counter.
//   CLK50MHZ   : clock
//   RST        : synchronous active-high reset
//   ROT_A/B    : raw quadrature channels
//   ROT_CENTER : raw push switch, 1 = pressed
//   rot_step   : one-cycle pulse per completed detent
//   rot_dir    : direction of last step (1 = clockwise), held between steps
//   rot_press  : one-cycle pulse on debounced press
//   rot_pos    : detent position (0 without ROTOR_POSITION_EN)
module rotor_decoder
  import rotor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 5000
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic       ROT_A,
  input  logic       ROT_B,
  input  logic       ROT_CENTER,
  output logic       rot_step,
  output logic       rot_dir,
  output logic       rot_press,
  output logic [7:0] rot_pos
);

  logic a_f, b_f, cen_f;
  logic [1:0] ab;

  rotor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk_i (CLK50MHZ),
    .rst_i (RST),
    .raw_i (ROT_A),
    .filt_o(a_f)
  );

  rotor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk_i (CLK50MHZ),
    .rst_i (RST),
    .raw_i (ROT_B),
    .filt_o(b_f)
  );

  rotor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_center (
    .clk_i (CLK50MHZ),
    .rst_i (RST),
    .raw_i (ROT_CENTER),
    .filt_o(cen_f)
  );

  assign ab = {a_f, b_f};

  rot_state_e state_d, state_q;
  logic       step_d, step_q;
  logic       dir_d, dir_q;
  logic       press_d, press_q;
  logic       cen_prev_q;

  // Codes not listed for a state (double-bit jumps) hold the state silently.
  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    unique case (state_q)
      StRest: begin
        if (ab == 2'b10)      state_d = StCw1;
        else if (ab == 2'b01) state_d = StCcw1;
      end
      StCw1: begin
        if (ab == 2'b11)                state_d = StCw2;
        else if (ab == ROT_REST_CODE)   state_d = StRest;
      end
      StCw2: begin
        if (ab == 2'b01)      state_d = StCw3;
        else if (ab == 2'b10) state_d = StCw1;
      end
      StCw3: begin
        if (ab == ROT_REST_CODE) begin
          state_d = StRest;
          step_d  = 1'b1;
          dir_d   = ROT_DIR_CW;
        end else if (ab == 2'b11) begin
          state_d = StCw2;
        end
      end
      StCcw1: begin
        if (ab == 2'b11)                state_d = StCcw2;
        else if (ab == ROT_REST_CODE)   state_d = StRest;
      end
      StCcw2: begin
        if (ab == 2'b10)      state_d = StCcw3;
        else if (ab == 2'b01) state_d = StCcw1;
      end
      StCcw3: begin
        if (ab == ROT_REST_CODE) begin
          state_d = StRest;
          step_d  = 1'b1;
          dir_d   = ROT_DIR_CCW;
        end else if (ab == 2'b11) begin
          state_d = StCcw2;
        end
      end
      default: state_d = StRest;
    endcase
  end

  assign press_d = cen_f & ~cen_prev_q;

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_q    <= StRest;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      press_q    <= 1'b0;
      cen_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      press_q    <= press_d;
      cen_prev_q <= cen_f;
    end
  end

  assign rot_step  = step_q;
  assign rot_dir   = dir_q;
  assign rot_press = press_q;

`ifdef ROTOR_POSITION_EN
  logic [7:0] pos_d, pos_q;

  // A press in the same cycle as a step takes priority and clears the count.
  always_comb begin
    pos_d = pos_q;
    if (press_d) begin
      pos_d = '0;
    end else if (step_d) begin
      pos_d = (dir_d == ROT_DIR_CW) ? pos_q + 8'd1 : pos_q - 8'd1;
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign rot_pos = pos_q;
`else
  assign rot_pos = 8'd0;
`endif

endmodule

// File: tb/tb_rotor_decoder.sv
// Self-checking bench for rotor_decoder with DEBOUNCE_CYCLES=4: directed detent,
// bounce, backtrack, press and reset scenarios, then random single-line moves,
// all checked against a detent-progress reference model.
module tb_rotor_decoder;
  import rotor_pkg::*;

  localparam int unsigned Deb = 4;

  logic       clk;
  logic       rst;
  logic       rot_a, rot_b, cen;
  logic       rot_step, rot_dir, rot_press;
  logic [7:0] rot_pos;

  rotor_decoder #(.DEBOUNCE_CYCLES(Deb)) dut (
    .CLK50MHZ  (clk),
    .RST       (rst),
    .ROT_A     (rot_a),
    .ROT_B     (rot_b),
    .ROT_CENTER(cen),
    .rot_step  (rot_step),
    .rot_dir   (rot_dir),
    .rot_press (rot_press),
    .rot_pos   (rot_pos)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Observed pulse counts (one count per high cycle, so stretched pulses show up).
  int step_cnt  = 0;
  int cw_cnt    = 0;
  int press_cnt = 0;

  always @(negedge clk) begin
    if (rot_step) begin
      step_cnt++;
      if (rot_dir) cw_cnt++;
    end
    if (rot_press) press_cnt++;
  end

  // Reference model: direction of the cycle in progress and how many
  // quarter-steps along it the encoder has travelled (0 = at rest).
  int m_dir     = 0;
  int m_depth   = 0;
  int m_steps   = 0;
  int m_cw      = 0;
  int m_presses = 0;
  int m_pos     = 0;
  int m_last    = 0;

  function automatic logic [1:0] seq_code(input int dir, input int idx);
    logic [1:0] c;
    if (dir > 0) begin
      case (idx)
        0: c = 2'b00;
        1: c = 2'b10;
        2: c = 2'b11;
        default: c = 2'b01;
      endcase
    end else begin
      case (idx)
        0: c = 2'b00;
        1: c = 2'b01;
        2: c = 2'b11;
        default: c = 2'b10;
      endcase
    end
    return c;
  endfunction

  function automatic void model_apply(input logic [1:0] code);
    if (m_depth == 0) begin
      if (code == 2'b10) begin
        m_dir = 1;  m_depth = 1;
      end else if (code == 2'b01) begin
        m_dir = -1; m_depth = 1;
      end
    end else if (code == seq_code(m_dir, (m_depth + 1) % 4)) begin
      m_depth++;
      if (m_depth == 4) begin
        m_depth = 0;
        m_steps++;
        if (m_dir > 0) begin
          m_cw++;
          m_last = 1;
          m_pos  = (m_pos + 1) & 255;
        end else begin
          m_last = 0;
          m_pos  = (m_pos + 255) & 255;
        end
      end
    end else if (code == seq_code(m_dir, m_depth - 1)) begin
      m_depth--;
    end
  endfunction

  function automatic int exp_pos();
`ifdef ROTOR_POSITION_EN
    return m_pos;
`else
    return 0;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".steps"}, step_cnt, m_steps);
    check_eq({tag, ".cw"}, cw_cnt, m_cw);
    check_eq({tag, ".press"}, press_cnt, m_presses);
    check_eq({tag, ".dir"}, int'(rot_dir), m_last);
    check_eq({tag, ".pos"}, int'(rot_pos), exp_pos());
  endtask

  task automatic set_ab(input logic a, input logic b, input int hold, input string tag);
    rot_a = a;
    rot_b = b;
    tick(hold);
    model_apply({a, b});
    check_all(tag);
  endtask

  task automatic set_cen(input logic c, input int hold, input string tag);
    if (c && !cen) begin
      m_presses++;
      m_pos = 0;
    end
    cen = c;
    tick(hold);
    check_all(tag);
  endtask

  // Pulse on one raw line shorter than the filter window; must leave no trace.
  task automatic glitch(input int line, input int len, input string tag);
    case (line)
      0: rot_a = ~rot_a;
      1: rot_b = ~rot_b;
      default: cen = ~cen;
    endcase
    tick(len);
    case (line)
      0: rot_a = ~rot_a;
      1: rot_b = ~rot_b;
      default: cen = ~cen;
    endcase
    tick(10);
    check_all(tag);
  endtask

  initial begin
    int first_press;
    int r;

    rst   = 1'b1;
    rot_a = 1'b0;
    rot_b = 1'b0;
    cen   = 1'b0;
    tick(3);
    check_eq("reset.step", int'(rot_step), 0);
    check_eq("reset.dir", int'(rot_dir), 0);
    check_eq("reset.press", int'(rot_press), 0);
    check_eq("reset.pos", int'(rot_pos), 0);
    rst = 1'b0;
    tick(2);

    // Counter-clockwise detent from 0 wraps to 255, clockwise wraps back.
    set_ab(0, 1, 10, "ccw1");
    set_ab(1, 1, 10, "ccw2");
    set_ab(1, 0, 10, "ccw3");
    set_ab(0, 0, 10, "ccw4");
    check_eq("ccw.one_step", step_cnt, 1);
    set_ab(1, 0, 10, "cw1");
    set_ab(1, 1, 10, "cw2");
    set_ab(0, 1, 10, "cw3");
    set_ab(0, 0, 10, "cw4");
    check_eq("cw.two_steps", step_cnt, 2);

    // Bounce: three short pulses on A never reach the filtered line.
    for (int i = 0; i < 3; i++) begin
      rot_a = 1'b1;
      tick(2);
      rot_a = 1'b0;
      tick(8);
      check_eq("bounce.filt_a", int'(dut.u_deb_a.filt_o), 0);
    end
    check_all("bounce");

    // Backtrack before completing the cycle.
    set_ab(1, 0, 10, "bt1");
    set_ab(1, 1, 10, "bt2");
    set_ab(1, 0, 10, "bt3");
    set_ab(0, 0, 10, "bt4");
    check_eq("bt.fsm_rest", int'(dut.state_q), int'(StRest));

    // Five clockwise detents, then press: clears position, one pulse only.
    for (int i = 0; i < 5; i++) begin
      set_ab(1, 0, 10, "five");
      set_ab(1, 1, 10, "five");
      set_ab(0, 1, 10, "five");
      set_ab(0, 0, 10, "five");
    end
    check_eq("five.pos", int'(rot_pos), exp_pos());
    m_presses++;
    m_pos = 0;
    cen = 1'b1;
    first_press = -1;
    // 2 synchroniser edges + Deb filter edges, then one more edge to register the pulse.
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (rot_press && first_press < 0) first_press = k;
    end
    check_eq("press.latency", first_press, 2 + Deb + 1);
    tick(8);
    check_all("press_hold");
    set_cen(0, 20, "release");

    // Reset while in CW2; resumed tail must not produce a step.
    set_ab(1, 0, 10, "rst_cw1");
    set_ab(1, 1, 10, "rst_cw2");
    rst = 1'b1;
    tick(1);
    check_eq("rst_mid.step", int'(rot_step), 0);
    check_eq("rst_mid.dir", int'(rot_dir), 0);
    check_eq("rst_mid.press", int'(rot_press), 0);
    check_eq("rst_mid.pos", int'(rot_pos), 0);
    rst = 1'b0;
    m_dir = 0; m_depth = 0; m_pos = 0; m_last = 0;
    tick(10);
    model_apply(2'b11);
    check_all("rst_idle");
    set_ab(0, 1, 10, "rst_res1");
    set_ab(0, 0, 10, "rst_res2");

    // Random single-line moves, short glitches and press toggles.
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        if (r % 2 == 1) set_ab(~rot_a, rot_b, int'($urandom_range(10, 14)), "rnd_a");
        else            set_ab(rot_a, ~rot_b, int'($urandom_range(10, 14)), "rnd_b");
      end else if (r < 8) begin
        glitch(int'($urandom_range(0, 2)), int'($urandom_range(1, Deb - 1)), "rnd_glitch");
      end else begin
        set_cen(~cen, int'($urandom_range(10, 14)), "rnd_cen");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
